// File: rtl/seq_divider.sv
// Multi-cycle RISC-V divide/remainder unit (DIV, DIVU, REM, REMU).
// It computes one restoring quotient bit per cycle and has valid/ready request and response ports.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] int_min = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic             is_rem_q;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH-1:0] quo_q;   // holds the dividend magnitude and fills with quotient bits from the LSB
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;

  logic             signed_op;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] final_val;

  assign signed_op = ~op[0];
  assign dvd_mag   = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag   = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign div_zero  = (divisor == '0);
  assign div_ovf   = signed_op && (dividend == int_min) && (divisor == '1);

  // One restoring step. The extra top bit of diff is the borrow, and it decides the quotient bit.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign q_bit     = ~diff[WIDTH];
  assign rem_next  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_next  = {quo_q[WIDTH-2:0], q_bit};
  assign final_val = is_rem_q ? (sign_r ? -rem_next : rem_next)
                              : (sign_q ? -quo_next : quo_next);

  // NOTE: every register here is updated with non-blocking assignments, so all the
  // right-hand sides see the pre-edge values no matter what order the statements are in.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      is_rem_q <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_rem_q <= op[1];
            sign_q   <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r   <= signed_op & dividend[WIDTH-1];
            quo_q    <= dvd_mag;
            dvs_q    <= dvs_mag;
            rem_q    <= '0;
            cnt_q    <= CW'(WIDTH);
            if (div_zero) begin
              result_q <= op[1] ? dividend : '1;
              state    <= DONE;
            end else if (div_ovf) begin
              result_q <= op[1] ? '0 : dividend;
              state    <= DONE;
            end else begin
              state    <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q <= final_val;
            state    <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign result     = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, backpressure, reset and a random regression,
// all checked through a result/latency scoreboard.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] result;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .dividend   (dividend),
    .divisor    (divisor),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;
  int   accept_cyc;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  // RISC-V reference model
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sd;
    sa = a;
    sd = b;
    if (b == '0) return o[1] ? a : '1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? '0 : a;
    if (o[0]) return o[1] ? (a % b) : (a / b);
    return o[1] ? W'(sa % sd) : W'(sa / sd);
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corners [4];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    case ($urandom_range(0, 5))
      0:       return corners[$urandom_range(0, 3)];
      1:       return W'($urandom_range(0, 20));
      2:       return -W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Starts at a negedge with the unit idle and ends at the negedge of the following idle cycle.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] want, input int stall, input bit poke, input string name);
    exp_t         e;
    exp_t         got;
    int           n;
    bit           busy_bad;
    bit           hold_bad;
    logic [W-1:0] held;
    bit           special;
    special = (b == '0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    e.res = want;
    e.lat = special ? 1 : W + 1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready_at_accept: got %b want 1", name, req_ready);
    end
    req_valid  = 1'b1;
    op         = o;
    dividend   = a;
    divisor    = b;
    resp_ready = (stall == 0);
    accept_cyc = cyc;
    scb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    op        = 2'($urandom);
    dividend  = W'($urandom);
    divisor   = W'($urandom);
    n         = 1;
    busy_bad  = 1'b0;
    while (resp_valid !== 1'b1 && n <= W + 4) begin
      if (req_ready !== 1'b0) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    got = scb.pop_front();
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s req_ready_busy: req_ready high while computing", name);
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: no resp_valid after %0d cycles", name, n);
      resp_ready = 1'b0;
      return;
    end
    checks++;
    if (n != got.lat) begin
      errors++;
      $display("FAIL %s latency: resp_valid in cycle %0d want %0d", name, n, got.lat);
    end
    held     = result;
    hold_bad = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        req_valid = 1'b1;
        op        = OP_DIVU;
        dividend  = 32'd50;
        divisor   = 32'd5;
      end
      @(negedge clk);
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || result !== held) hold_bad = 1'b1;
    end
    if (stall > 0) begin
      checks++;
      if (hold_bad) begin
        errors++;
        $display("FAIL %s hold: response not held stable during stall (result %h, first seen %h)",
                 name, result, held);
      end
    end
    resp_ready = 1'b1;
    checks++;
    if (result !== got.res) begin
      errors++;
      $display("FAIL %s result: got %h want %h", name, result, got.res);
    end
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s release: req_ready %b resp_valid %b want 1 0", name, req_ready, resp_valid);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    op         = '0;
    dividend   = '0;
    divisor    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_state: req_ready %b resp_valid %b result %h want 1 0 0",
               req_ready, resp_valid, result);
    end
  endtask

  task automatic test_directed();
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 0, 0, "divu_100_7");
    run_op(OP_REMU, 32'd100, 32'd7, 32'd2, 0, 0, "remu_100_7");
    run_op(OP_DIV, -32'd7, 32'd2, 32'hFFFF_FFFD, 0, 0, "div_m7_2");
    run_op(OP_REM, -32'd7, 32'd2, 32'hFFFF_FFFF, 0, 0, "rem_m7_2");
    run_op(OP_DIV, 32'd7, -32'd2, 32'hFFFF_FFFD, 0, 0, "div_7_m2");
    run_op(OP_REM, 32'd7, -32'd2, 32'd1, 0, 0, "rem_7_m2");
  endtask

  task automatic test_special();
    run_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0, "divu_by_zero");
    run_op(OP_REM, 32'd5, 32'd0, 32'd5, 0, 0, "rem_by_zero");
    run_op(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0, "div_by_zero");
    run_op(OP_REMU, 32'd5, 32'd0, 32'd5, 0, 0, "remu_by_zero");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, "div_overflow");
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 0, "rem_overflow");
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 0, "divu_no_overflow");
  endtask

  task automatic test_backpressure();
    run_op(OP_DIV, 32'd20, 32'd3, 32'd6, 6, 1, "backpressure_div_20_3");
  endtask

  task automatic test_reset_mid_calc();
    req_valid  = 1'b1;
    op         = OP_DIVU;
    dividend   = 32'd1000;
    divisor    = 32'd7;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL mid_calc_reset: req_ready %b resp_valid %b result %h want 1 0 0",
               req_ready, resp_valid, result);
    end
    resp_ready = 1'b0;
    run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 0, 0, "divu_9_3_after_reset");
  endtask

  task automatic test_back_to_back();
    int c0;
    int c1;
    int c2;
    run_op(OP_DIVU, 32'd1234, 32'd10, 32'd123, 0, 0, "b2b_0");
    c0 = accept_cyc;
    run_op(OP_REMU, 32'd1234, 32'd10, 32'd4, 0, 0, "b2b_1");
    c1 = accept_cyc;
    run_op(OP_DIV, -32'd1234, 32'd10, -32'd123, 0, 0, "b2b_2");
    c2 = accept_cyc;
    checks++;
    if (c1 - c0 != W + 2 || c2 - c1 != W + 2) begin
      errors++;
      $display("FAIL back_to_back_period: got %0d and %0d cycles want %0d", c1 - c0, c2 - c1, W + 2);
    end
  endtask

  task automatic test_random(input int count);
    logic [1:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < count; i++) begin
      o = 2'($urandom);
      a = pick_operand();
      b = pick_operand();
      run_op(o, a, b, model(o, a, b), $urandom_range(0, 3), 0, $sformatf("rand_%0d", i));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_special();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_random(1200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
